// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg: shared types and sizing helpers for the PLL reset sequencer.
package pll_seq_pkg;

    // Sequencer states. The codes are visible on state_o for debug LEDs.
    typedef enum logic [1:0] {
        ST_PLL_RST   = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_STABLE    = 2'd2,
        ST_RUN       = 2'd3
    } seq_state_e;

    // Attempt counter width and its saturation value.
    localparam int unsigned          RETRY_W   = 4;
    localparam logic [RETRY_W-1:0]   RETRY_SAT = '1;

    // Largest of three cycle counts; the shared phase counter is sized for it.
    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Bits needed to hold terminal count (max_val - 1); never less than 1.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: synchronises the raw active-low user button, filters out
// bounce, and emits a one-cycle pulse when the filtered level goes from
// released to pressed.
module btn_debounce
    import pll_seq_pkg::*;
#(
    parameter int unsigned DEBOUNCE = 270000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n_i,
    output logic press_o
);

    localparam int unsigned      CNT_W    = cnt_width(DEBOUNCE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

    logic             btn_meta_q, btn_meta_d;
    logic             btn_sync_q, btn_sync_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;

    // Next state: shift the synchronizer, count consecutive cycles in which the
    // synchronized button disagrees with the filtered level, flip at terminal count.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        btn_meta_d = btn_n_i;
        btn_sync_d = btn_meta_q;
        cnt_d      = '0;
        level_d    = level_q;
        press_d    = 1'b0;
        if (btn_sync_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = btn_sync_q;
                press_d = ~btn_sync_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Registers; reset parks the synchronizer and the filtered level at "released".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            btn_meta_q <= 1'b1;
            btn_sync_q <= 1'b1;
            cnt_q      <= '0;
            level_q    <= 1'b1;
            press_q    <= 1'b0;
        end else begin
            btn_meta_q <= btn_meta_d;
            btn_sync_q <= btn_sync_d;
            cnt_q      <= cnt_d;
            level_q    <= level_d;
            press_q    <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/pll_reset_seq.sv
// pll_reset_seq: power-up / recovery sequencer for the board PLL. Pulses the
// PLL reset, waits for lock, requires lock to stay up for a programmed time
// before releasing the system reset, retries failed lock attempts and latches
// a sticky fault after too many of them. The user button re-runs the sequence.
module pll_reset_seq
    import pll_seq_pkg::*;
#(
    parameter int unsigned PLL_RST_CYCLES = 16,
    parameter int unsigned LOCK_TIMEOUT   = 27000,
    parameter int unsigned LOCK_STABLE    = 2700,
    parameter int unsigned MAX_RETRY      = 7,
    parameter int unsigned DEBOUNCE       = 270000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pll_lock,
    input  logic               btn_n,
    output logic               pll_reset,
    output logic               sys_rst_n,
    output logic               fault,
    output logic [RETRY_W-1:0] retry_cnt,
    output logic [1:0]         state_o
);

    // One phase counter serves every state, so it is sized for the longest phase.
    localparam int unsigned CNT_W = cnt_width(max3(PLL_RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE));

    localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
    // The WAIT_LOCK cycle that saw lock already counts as the first locked cycle.
    localparam logic [CNT_W-1:0]   STABLE_FIRST = CNT_W'(1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRY);

    logic               lock_meta_q, lock_meta_d;
    logic               lock_sync_q, lock_sync_d;
    seq_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic               fault_q, fault_d;
    logic               pll_reset_q, pll_reset_d;
    logic               sys_rst_n_q, sys_rst_n_d;
    logic               btn_press;

    btn_debounce #(
        .DEBOUNCE (DEBOUNCE)
    ) u_btn_debounce (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_n_i (btn_n),
        .press_o (btn_press)
    );

    // Sequencer next state, phase counter, retry bookkeeping and registered outputs.
    always_comb begin
        lock_meta_d = pll_lock;
        lock_sync_d = lock_meta_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        retry_d     = retry_q;
        fault_d     = fault_q;

        if (fault_q) begin
            // Parked with the PLL held in reset; only a button press restarts.
            state_d = ST_PLL_RST;
            cnt_d   = '0;
            if (btn_press) begin
                fault_d = 1'b0;
                retry_d = '0;
            end
        end else begin
            unique case (state_q)
                ST_PLL_RST: begin
                    if (btn_press) begin
                        cnt_d = '0;
                    end else if (cnt_q >= RST_LAST) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end

                ST_WAIT_LOCK: begin
                    // Lock takes priority over a timeout falling in the same cycle.
                    if (lock_sync_q) begin
                        state_d = ST_STABLE;
                        cnt_d   = STABLE_FIRST;
                    end else if (cnt_q >= TIMEOUT_LAST) begin
                        retry_d = (retry_q == RETRY_SAT) ? retry_q : retry_q + 1'b1;
                        state_d = ST_PLL_RST;
                        cnt_d   = '0;
                        if (retry_d >= RETRY_LIMIT) begin
                            fault_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end

                ST_STABLE: begin
                    if (btn_press) begin
                        state_d = ST_PLL_RST;
                        cnt_d   = '0;
                    end else if (!lock_sync_q) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q >= STABLE_LAST) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end

                ST_RUN: begin
                    // Lock loss is a full re-sequence and does not count as a retry.
                    if (btn_press || !lock_sync_q) begin
                        state_d = ST_PLL_RST;
                        cnt_d   = '0;
                    end
                end
            endcase
        end

        // Outputs are decoded from the next state so they change on the same
        // edge as the state register and never glitch.
        pll_reset_d = fault_d || (state_d == ST_PLL_RST);
        sys_rst_n_d = !fault_d && (state_d == ST_RUN);
    end

    // Lock synchronizer, sequencer state and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_meta_q <= 1'b0;
            lock_sync_q <= 1'b0;
            state_q     <= ST_PLL_RST;
            cnt_q       <= '0;
            retry_q     <= '0;
            fault_q     <= 1'b0;
            pll_reset_q <= 1'b1;
            sys_rst_n_q <= 1'b0;
        end else begin
            lock_meta_q <= lock_meta_d;
            lock_sync_q <= lock_sync_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            fault_q     <= fault_d;
            pll_reset_q <= pll_reset_d;
            sys_rst_n_q <= sys_rst_n_d;
        end
    end

    assign pll_reset = pll_reset_q;
    assign sys_rst_n = sys_rst_n_q;
    assign fault     = fault_q;
    assign retry_cnt = retry_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_pll_reset_seq.sv
// tb_pll_reset_seq: scenario tasks plus randomized traffic, checked against a
// phase-level reference model of the sequencer kept in this file.
module tb_pll_reset_seq;

    localparam int PLL_RST_CYCLES = 4;
    localparam int LOCK_TIMEOUT   = 20;
    localparam int LOCK_STABLE    = 8;
    localparam int MAX_RETRY      = 2;
    localparam int DEBOUNCE       = 5;

    localparam int P_RST = 0, P_WAIT = 1, P_STABLE = 2, P_RUN = 3;

    // {state_o, pll_reset, sys_rst_n, fault, retry_cnt}
    localparam logic [8:0] RESET_VEC = {2'd0, 1'b1, 1'b0, 1'b0, 4'd0};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pll_lock = 1'b0;
    logic       btn_n = 1'b1;
    logic       pll_reset, sys_rst_n, fault;
    logic [3:0] retry_cnt;
    logic [1:0] state_o;

    int vectors = 0;
    int miscompares = 0;

    pll_reset_seq #(
        .PLL_RST_CYCLES (PLL_RST_CYCLES),
        .LOCK_TIMEOUT   (LOCK_TIMEOUT),
        .LOCK_STABLE    (LOCK_STABLE),
        .MAX_RETRY      (MAX_RETRY),
        .DEBOUNCE       (DEBOUNCE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pll_lock  (pll_lock),
        .btn_n     (btn_n),
        .pll_reset (pll_reset),
        .sys_rst_n (sys_rst_n),
        .fault     (fault),
        .retry_cnt (retry_cnt),
        .state_o   (state_o)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int m_phase;      // current phase
    int m_elapsed;    // cycles spent in PLL_RST or unlocked cycles in WAIT_LOCK
    int m_locked;     // consecutive locked cycles seen since lock was first observed
    int m_retry;
    bit m_fault;
    bit m_level;      // debounced button level (1 = released)
    int m_disagree;   // consecutive synchronized cycles differing from m_level
    bit m_press;      // press event visible to the sequencer next cycle
    bit lock_pipe[$];
    bit btn_pipe[$];

    task automatic model_reset();
        m_phase = P_RST; m_elapsed = 0; m_locked = 0; m_retry = 0; m_fault = 0;
        m_level = 1; m_disagree = 0; m_press = 0;
        lock_pipe.delete(); lock_pipe.push_back(1'b0); lock_pipe.push_back(1'b0);
        btn_pipe.delete();  btn_pipe.push_back(1'b1);  btn_pipe.push_back(1'b1);
    endtask

    task automatic enter_rst();
        m_phase = P_RST; m_elapsed = 0;
    endtask

    // One clock edge: the inputs sampled now reach the decisions two edges later.
    task automatic model_step();
        bit lk, bs, pr, new_press;
        lk = lock_pipe[0];
        bs = btn_pipe[0];
        pr = m_press;
        if (m_fault) begin
            if (pr) begin m_fault = 0; m_retry = 0; enter_rst(); end
        end else begin
            case (m_phase)
                P_RST: begin
                    if (pr) m_elapsed = 0;
                    else begin
                        m_elapsed++;
                        if (m_elapsed == PLL_RST_CYCLES) begin m_phase = P_WAIT; m_elapsed = 0; end
                    end
                end
                P_WAIT: begin
                    if (lk) begin m_phase = P_STABLE; m_locked = 1; end
                    else begin
                        m_elapsed++;
                        if (m_elapsed == LOCK_TIMEOUT) begin
                            if (m_retry < 15) m_retry++;
                            enter_rst();
                            if (m_retry >= MAX_RETRY) m_fault = 1;
                        end
                    end
                end
                P_STABLE: begin
                    if (pr) enter_rst();
                    else if (!lk) begin m_phase = P_WAIT; m_elapsed = 0; end
                    else begin
                        m_locked++;
                        if (m_locked >= LOCK_STABLE) m_phase = P_RUN;
                    end
                end
                default: begin
                    if (pr || !lk) enter_rst();
                end
            endcase
        end
        new_press = 0;
        if (bs != m_level) begin
            m_disagree++;
            if (m_disagree == DEBOUNCE) begin
                m_level = bs; m_disagree = 0; new_press = !bs;
            end
        end else begin
            m_disagree = 0;
        end
        m_press = new_press;
        void'(lock_pipe.pop_front()); lock_pipe.push_back(pll_lock);
        void'(btn_pipe.pop_front());  btn_pipe.push_back(btn_n);
    endtask

    function automatic logic [8:0] model_vec();
        logic pr_exp, sys_exp;
        pr_exp  = m_fault || (m_phase == P_RST);
        sys_exp = !m_fault && (m_phase == P_RUN);
        return {2'(m_phase), pr_exp, sys_exp, m_fault, 4'(m_retry)};
    endfunction

    function automatic logic [8:0] dut_vec();
        return {state_o, pll_reset, sys_rst_n, fault, retry_cnt};
    endfunction

    // One clock: model and DUT see the same inputs at the posedge; sampling happens at negedge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; pll_lock = 1'b0; btn_n = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0; pll_lock = 1'b0; btn_n = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        vectors++;
        if (dut_vec() !== RESET_VEC) begin
            miscompares++;
            $display("FAIL reset_values: dut=%b want=%b", dut_vec(), RESET_VEC);
        end
        rst_n = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            tick();
            vectors++;
            if (dut_vec() !== model_vec()) begin
                miscompares++;
                $display("FAIL reset_release_c%0d: dut=%b model=%b", c, dut_vec(), model_vec());
            end
        end
    endtask

    task automatic test_nominal();
        int t_rst_low, t_sys;
        t_rst_low = -1; t_sys = -1;
        do_reset();
        for (int c = 1; c <= 40; c++) begin
            tick();
            vectors++;
            if (dut_vec() !== model_vec()) begin
                miscompares++;
                $display("FAIL nominal_c%0d: dut=%b model=%b", c, dut_vec(), model_vec());
            end
            if (t_rst_low < 0 && pll_reset === 1'b0) t_rst_low = c;
            if (t_sys < 0 && sys_rst_n === 1'b1) t_sys = c;
            if (c == 10) pll_lock = 1'b1;
        end
        vectors++;
        if (t_rst_low != PLL_RST_CYCLES) begin
            miscompares++;
            $display("FAIL nominal_pll_reset_width: got=%0d want=%0d", t_rst_low, PLL_RST_CYCLES);
        end
        vectors++;
        if (t_sys != 10 + LOCK_STABLE + 2) begin
            miscompares++;
            $display("FAIL nominal_sys_release: got=%0d want=%0d", t_sys, 10 + LOCK_STABLE + 2);
        end
        vectors++;
        if (retry_cnt !== 4'd0) begin
            miscompares++;
            $display("FAIL nominal_retry: got=%0d want=0", retry_cnt);
        end
    endtask

    task automatic test_glitchy_lock();
        int  t_sys;
        bit  saw_stable, saw_back;
        t_sys = -1; saw_stable = 0; saw_back = 0;
        do_reset();
        for (int c = 1; c <= 40; c++) begin
            tick();
            vectors++;
            if (dut_vec() !== model_vec()) begin
                miscompares++;
                $display("FAIL glitch_c%0d: dut=%b model=%b", c, dut_vec(), model_vec());
            end
            if (state_o === 2'd2) saw_stable = 1;
            if (saw_stable && t_sys < 0 && state_o === 2'd1) saw_back = 1;
            if (t_sys < 0 && sys_rst_n === 1'b1) t_sys = c;
            if (c == 10) pll_lock = 1'b1;
            if (c == 15) pll_lock = 1'b0;
            if (c == 16) pll_lock = 1'b1;
        end
        vectors++;
        if (!saw_back) begin
            miscompares++;
            $display("FAIL glitch_return_wait: got=%0d want=1", saw_back);
        end
        vectors++;
        if (t_sys != 16 + LOCK_STABLE + 2) begin
            miscompares++;
            $display("FAIL glitch_sys_release: got=%0d want=%0d", t_sys, 16 + LOCK_STABLE + 2);
        end
    endtask

    task automatic test_fault();
        int t_fault, t_clear;
        t_fault = -1; t_clear = -1;
        do_reset();
        for (int c = 1; c <= 100 && t_fault < 0; c++) begin
            tick();
            vectors++;
            if (dut_vec() !== model_vec()) begin
                miscompares++;
                $display("FAIL fault_c%0d: dut=%b model=%b", c, dut_vec(), model_vec());
            end
            if (fault === 1'b1) t_fault = c;
        end
        vectors++;
        if (t_fault != MAX_RETRY * (PLL_RST_CYCLES + LOCK_TIMEOUT)) begin
            miscompares++;
            $display("FAIL fault_time: got=%0d want=%0d", t_fault, MAX_RETRY * (PLL_RST_CYCLES + LOCK_TIMEOUT));
        end
        repeat (10) tick();
        vectors++;
        if ({state_o, fault, retry_cnt, pll_reset, sys_rst_n} !== {2'd0, 1'b1, 4'(MAX_RETRY), 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL fault_hold: got=%b want=%b", {state_o, fault, retry_cnt, pll_reset, sys_rst_n},
                     {2'd0, 1'b1, 4'(MAX_RETRY), 1'b1, 1'b0});
        end
        btn_n = 1'b0;
        for (int c = 1; c <= 20 && t_clear < 0; c++) begin
            tick();
            vectors++;
            if (dut_vec() !== model_vec()) begin
                miscompares++;
                $display("FAIL fault_clear_c%0d: dut=%b model=%b", c, dut_vec(), model_vec());
            end
            if (fault === 1'b0) t_clear = c;
        end
        vectors++;
        if (t_clear != DEBOUNCE + 3 || retry_cnt !== 4'd0) begin
            miscompares++;
            $display("FAIL fault_clear: got t=%0d retry=%0d want t=%0d retry=0", t_clear, retry_cnt, DEBOUNCE + 3);
        end
        btn_n = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            tick();
            vectors++;
            if (dut_vec() !== model_vec()) begin
                miscompares++;
                $display("FAIL fault_after_c%0d: dut=%b model=%b", c, dut_vec(), model_vec());
            end
        end
    endtask

    task automatic test_lock_loss_run();
        int t_low, t_prh, t_prl, t_sys;
        t_low = -1; t_prh = -1; t_prl = -1; t_sys = -1;
        do_reset();
        pll_lock = 1'b1;
        for (int c = 1; c <= 60 && sys_rst_n !== 1'b1; c++) tick();
        vectors++;
        if (sys_rst_n !== 1'b1) begin
            miscompares++;
            $display("FAIL loss_reach_run: timeout sys_rst_n=%b want=1", sys_rst_n);
        end
        pll_lock = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            vectors++;
            if (dut_vec() !== model_vec()) begin
                miscompares++;
                $display("FAIL loss_c%0d: dut=%b model=%b", c, dut_vec(), model_vec());
            end
            if (t_low < 0 && sys_rst_n === 1'b0) t_low = c;
            if (t_prh < 0 && pll_reset === 1'b1) t_prh = c;
            if (t_prh >= 0 && t_prl < 0 && pll_reset === 1'b0) t_prl = c;
            if (t_low >= 0 && t_sys < 0 && sys_rst_n === 1'b1) t_sys = c;
            if (c == 5) pll_lock = 1'b1;
        end
        vectors++;
        if (t_low != 3 || t_prh != 3) begin
            miscompares++;
            $display("FAIL loss_sys_drop: got sys=%0d prst=%0d want 3,3", t_low, t_prh);
        end
        vectors++;
        if (t_prl - t_prh != PLL_RST_CYCLES) begin
            miscompares++;
            $display("FAIL loss_pll_reset_width: got=%0d want=%0d", t_prl - t_prh, PLL_RST_CYCLES);
        end
        vectors++;
        if (t_sys != 5 + LOCK_STABLE + 2 || retry_cnt !== 4'd0) begin
            miscompares++;
            $display("FAIL loss_relock: got t=%0d retry=%0d want t=%0d retry=0", t_sys, retry_cnt, 5 + LOCK_STABLE + 2);
        end
    endtask

    task automatic test_button();
        int sys_drops, rises;
        logic prev;
        sys_drops = 0; rises = 0;
        do_reset();
        pll_lock = 1'b1;
        for (int c = 1; c <= 60 && sys_rst_n !== 1'b1; c++) tick();
        vectors++;
        if (sys_rst_n !== 1'b1) begin
            miscompares++;
            $display("FAIL button_reach_run: timeout sys_rst_n=%b want=1", sys_rst_n);
        end
        for (int k = 0; k < 30; k++) begin
            btn_n = ((k / 3) % 2 == 1);
            tick();
            vectors++;
            if (dut_vec() !== model_vec()) begin
                miscompares++;
                $display("FAIL bounce_k%0d: dut=%b model=%b", k, dut_vec(), model_vec());
            end
            if (sys_rst_n !== 1'b1) sys_drops++;
        end
        btn_n = 1'b1;
        repeat (4) tick();
        vectors++;
        if (sys_drops != 0) begin
            miscompares++;
            $display("FAIL bounce_no_action: got=%0d drops want=0", sys_drops);
        end
        prev = pll_reset;
        btn_n = 1'b0;
        for (int c = 1; c <= 48; c++) begin
            if (c == 9) btn_n = 1'b1;
            tick();
            vectors++;
            if (dut_vec() !== model_vec()) begin
                miscompares++;
                $display("FAIL press_c%0d: dut=%b model=%b", c, dut_vec(), model_vec());
            end
            if (!prev && pll_reset === 1'b1) rises++;
            prev = pll_reset;
        end
        vectors++;
        if (rises != 1 || sys_rst_n !== 1'b1) begin
            miscompares++;
            $display("FAIL press_one_resequence: got rises=%0d sys=%b want 1,1", rises, sys_rst_n);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        pll_lock = 1'b1;
        for (int c = 1; c <= 30 && state_o !== 2'd2; c++) tick();
        vectors++;
        if (state_o !== 2'd2) begin
            miscompares++;
            $display("FAIL async_reach_stable: timeout state=%0d want=2", state_o);
        end
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        vectors++;
        if (dut_vec() !== RESET_VEC) begin
            miscompares++;
            $display("FAIL async_reset_values: dut=%b want=%b", dut_vec(), RESET_VEC);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            tick();
            vectors++;
            if (dut_vec() !== model_vec()) begin
                miscompares++;
                $display("FAIL async_after_c%0d: dut=%b model=%b", c, dut_vec(), model_vec());
            end
        end
    endtask

    task automatic test_random();
        int lock_left, btn_left;
        lock_left = 0; btn_left = 0;
        do_reset();
        for (int c = 1; c <= 1500; c++) begin
            if (lock_left == 0) begin
                pll_lock  = ($urandom_range(0, 3) != 0);
                lock_left = $urandom_range(1, 30);
            end
            if (btn_left == 0) begin
                btn_n    = ($urandom_range(0, 3) != 0);
                btn_left = $urandom_range(1, 12);
            end
            lock_left--; btn_left--;
            tick();
            vectors++;
            if (dut_vec() !== model_vec()) begin
                miscompares++;
                $display("FAIL random_c%0d: dut=%b model=%b", c, dut_vec(), model_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_glitchy_lock();
        test_fault();
        test_lock_loss_run();
        test_button();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
